// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential M-extension multiply/divide unit:
// op codes, FSM state encoding and the fixed results of the divide corner cases.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b00001;
  localparam logic [4:0] OP_MULH   = 5'b00101;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01001;
  localparam logic [4:0] OP_DIV    = 5'b10001;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b11001;
  localparam logic [4:0] OP_REMU   = 5'b11101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT     = 32'h8000_0000;
  localparam logic [31:0] OVF_REM      = 32'h0000_0000;

  function automatic logic is_m_op(input logic [4:0] op);
    logic hit;
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: hit = 1'b1;
      default:                          hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi, lo} accumulator: shift-add for multiply
// (multiplier in lo), restoring shift-subtract for divide ({remainder, quotient}).
import muldiv_pkg::*;

module muldiv_step (
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] diff;

  always_comb begin
    sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    trial = {acc[63:32], acc[31]};
    ge    = (trial >= {1'b0, opnd});
    // when the trial fits, the true difference is below the divisor, so 32 bits suffice
    diff  = trial[31:0] - opnd;
    if (is_div) begin
      acc_next = ge ? {diff, acc[30:0], 1'b1} : {trial[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32 M-extension multiply/divide unit with flush and pipeline stall.
// Build option: MULDIV_SEQ_FAST_MUL_EN selects a single-cycle multiplier.
//
// state | meaning
// IDLE  | waiting for start_i with a valid M op code
// RUN   | 32 radix-2 iterations on the magnitudes
// FIX   | sign correction and result selection
// DONE  | result_o valid, done_o pulsed for one cycle
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_t            state, state_n;
  logic [4:0]        cnt;
  logic [4:0]        op_q;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [XLEN-1:0]   opnd;
  logic              neg_res, neg_rem;
  logic [XLEN-1:0]   result_q;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, bypass, accept;
  logic [XLEN-1:0]   bypass_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, fix_res;
`ifdef MULDIV_SEQ_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p;
`endif

  always_comb begin
    a_signed   = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    b_signed   = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg      = a_signed & a_i[XLEN-1];
    b_neg      = b_signed & b_i[XLEN-1];
    a_mag      = a_neg ? -a_i : a_i;
    b_mag      = b_neg ? -b_i : b_i;
    div_zero   = op_i[4] && (b_i == '0);
    div_ovf    = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (a_i == OVF_DIVIDEND) && (b_i == OVF_DIVISOR);
    bypass     = div_zero | div_ovf;
    bypass_res = '0;
    // op bit 3 separates remainder ops from quotient ops within the divide group
    if (div_zero) begin
      bypass_res = op_i[3] ? a_i : DIV0_QUOT;
    end else if (div_ovf) begin
      bypass_res = op_i[3] ? OVF_REM : OVF_QUOT;
    end
`ifdef MULDIV_SEQ_FAST_MUL_EN
    // sign-extended 64x64 product, low 64 bits equal the 33x33 signed product
    fast_p = {{XLEN{a_neg}}, a_i} * {{XLEN{b_neg}}, b_i};
    if (!op_i[4]) begin
      bypass     = 1'b1;
      bypass_res = (op_i == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif
    accept = (state == S_IDLE) && start_i && is_m_op(op_i) && !flush_i && !reset;
  end

  always_comb begin
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op_q == OP_MUL) begin
      fix_res = prod[XLEN-1:0];
    end else if (!op_q[4]) begin
      fix_res = prod[2*XLEN-1:XLEN];
    end else if (op_q[3]) begin
      fix_res = rem;
    end else begin
      fix_res = quot;
    end
  end

  muldiv_step u_step (
    .is_div   (op_q[4]),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = bypass ? S_DONE : S_RUN;
      S_RUN:   if (cnt == 5'd31) state_n = S_FIX;
      S_FIX:   state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush_i) state_n = S_IDLE;
    busy_o   = (state == S_RUN) || (state == S_FIX);
    done_o   = (state == S_DONE);
    stall_o  = busy_o | accept;
    result_o = done_o ? result_q : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept) begin
      op_q    <= op_i;
      cnt     <= '0;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      if (op_i[4]) begin
        acc  <= {{XLEN{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{XLEN{1'b0}}, b_mag};
        opnd <= a_mag;
      end
      if (bypass) result_q <= bypass_res;
    end else if (state == S_RUN) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
    end else if (state == S_FIX) begin
      result_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results and due cycles are queued
// at issue and checked when done_o pulses; also covers flush, reset and stall.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int ITER_LAT = 34;
  localparam int BYP_LAT  = 1;

  logic        clk = 1'b0;
  logic        reset, start_i, flush_i;
  logic [4:0]  op_i;
  logic [31:0] a_i, b_i, result_o;
  logic        busy_o, stall_o, done_o;

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  bit   mon_en = 1'b0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[13] = '{
    '{OP_DIVU,   32'd100,        32'd7,          32'd14},
    '{OP_REMU,   32'd100,        32'd7,          32'd2},
    '{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD},
    '{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF},
    '{OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF},
    '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000},
    '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000},
    '{OP_REMU,   32'd5,          32'd0,          32'd5},
    '{OP_DIV,    32'd7,          32'd0,          32'hFFFF_FFFF},
    '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000},
    '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE},
    '{OP_MUL,    32'd3,          32'hFFFF_FFFB,  32'hFFFF_FFF1},
    '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF}
  };

  logic [4:0] ops[8] = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                         OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[4] && (b == 0)) return BYP_LAT;
    if (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
      return BYP_LAT;
`ifdef MULDIV_SEQ_FAST_MUL_EN
    if (!op[4]) return BYP_LAT;
`endif
    return ITER_LAT;
  endfunction

  // drive one request in IDLE; the accept edge closes the driven cycle
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp, input string tag);
    int lat;
    lat = ref_lat(op, a, b);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    if (push) sb.push_back('{exp, cyc + lat, tag});
    #1;
    check({tag, "_stall_accept"}, 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 5'b0;
    check({tag, "_busy_after"}, 32'(busy_o), (lat == ITER_LAT) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (done_o) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done_o), 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_result"}, result_o, e.res);
          check({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
          check({e.tag, "_stall_done"}, 32'(stall_o), 32'd0);
        end
      end else begin
        check("result_zero_idle", result_o, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [4:0]  op;
    reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 5'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 13; i++) begin
      issue(dir[i].op, dir[i].a, dir[i].b, 1'b1, dir[i].exp, $sformatf("dir%0d", i));
      wait_done();
    end

    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue(op, a, b, 1'b1, ref_result(op, a, b), $sformatf("rnd%0d", i));
      wait_done();
    end

    // flush at RUN cycle 10 with a competing start
    issue(OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, "flush_run");
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1; start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd50; b_i = 32'd5;
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0; op_i = 5'b0;
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_stall", 32'(stall_o), 32'd0);
    repeat (40) @(posedge clk);

    // flush and start together in IDLE
    #1;
    flush_i = 1'b1; start_i = 1'b1; op_i = OP_DIVU;
    #1 check("flush_idle_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; start_i = 1'b0; op_i = 5'b0;
    check("flush_idle_busy", 32'(busy_o), 32'd0);
    repeat (40) @(posedge clk);

    // reset mid-RUN
    issue(OP_DIV, 32'hFFFF_0000, 32'd9, 1'b0, 32'd0, "reset_run");
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rst_run_busy", 32'(busy_o), 32'd0);
    check("rst_run_stall", 32'(stall_o), 32'd0);
    check("rst_run_done", 32'(done_o), 32'd0);
    check("rst_run_result", result_o, 32'd0);
    repeat (40) @(posedge clk);

    // start held high with a non-M code, then switched to DIVU in IDLE
    #1;
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd10;
    sb.push_back('{32'd100, cyc + ITER_LAT, "b2b_first"});
    @(posedge clk); #1;
    op_i = 5'b00000;
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    check("b2b_add_busy", 32'(busy_o), 32'd0);
    check("b2b_add_stall", 32'(stall_o), 32'd0);
    op_i = OP_DIVU; a_i = 32'd77; b_i = 32'd7;
    sb.push_back('{32'd11, cyc + ITER_LAT, "b2b_second"});
    #1 check("b2b_divu_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 5'b0;
    check("b2b_divu_busy", 32'(busy_o), 32'd1);
    wait_done();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
